// File: rtl/dma_priority_arbiter.sv
// Channel request arbiter for the 4-channel DMA controller: samples DREQ and
// software requests, picks a winner by fixed/rotating priority, and drives DACK.
module dma_priority_arbiter #(
  parameter int          NUM_CH     = 4,
  parameter logic [7:0]  PRIO_RESET = 8'b11_10_01_00
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [NUM_CH-1:0] DREQ,
  input  logic              dreqSense,
  input  logic              dackSense,
  input  logic              priorityType,
  input  logic [NUM_CH-1:0] maskReg,
  input  logic              reqWrite,
  input  logic [2:0]        reqData,
  input  logic              masterClear,
  input  logic              HLDA,
  input  logic              serviceDone,
  input  logic              terminalCount,
  output logic              hrqReq,
  output logic              grantValid,
  output logic [1:0]        grantCh,
  output logic [NUM_CH-1:0] DACK,
  output logic [7:0]        priorityOrder
);

  typedef enum logic [1:0] {IDLE, REQ, ACTIVE} state_t;

  state_t            r_state;
  logic [NUM_CH-1:0] r_dreqQ;
  logic [NUM_CH-1:0] r_softReq;
  logic              r_hrqReq;
  logic              r_grantValid;
  logic [1:0]        r_grantCh;
  logic [7:0]        r_prio;

  state_t            w_stateNext;
  logic [NUM_CH-1:0] w_softNext;
  logic              w_hrqNext;
  logic              w_gvNext;
  logic [1:0]        w_gchNext;
  logic [7:0]        w_prioNext;
  logic [NUM_CH-1:0] w_effReq;
  logic [1:0]        w_winner;
  logic              w_found;
  logic [7:0]        w_rotated;

  assign w_effReq = ((r_dreqQ ^ {NUM_CH{dreqSense}}) & ~maskReg) | r_softReq;

  // Serviced channel drops to the lowest slot; its successor becomes highest.
  assign w_rotated = {r_grantCh, r_grantCh + 2'd3, r_grantCh + 2'd2, r_grantCh + 2'd1};

  always_comb begin
    w_winner = 2'd0;
    w_found  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!w_found && w_effReq[r_prio[2*i +: 2]]) begin
        w_winner = r_prio[2*i +: 2];
        w_found  = 1'b1;
      end
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_softNext  = r_softReq;
    w_hrqNext   = r_hrqReq;
    w_gvNext    = r_grantValid;
    w_gchNext   = r_grantCh;
    w_prioNext  = r_prio;
    if (!priorityType) w_prioNext = PRIO_RESET;

    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_stateNext = REQ;
          w_gchNext   = w_winner;
          w_gvNext    = 1'b1;
          w_hrqNext   = 1'b1;
        end
      end
      REQ: begin
        if (!w_effReq[r_grantCh] && !HLDA) begin
          w_stateNext = IDLE;
          w_gvNext    = 1'b0;
          w_hrqNext   = 1'b0;
        end else if (HLDA) begin
          w_stateNext = ACTIVE;
        end
      end
      ACTIVE: begin
        if (serviceDone) begin
          w_stateNext = IDLE;
          w_gvNext    = 1'b0;
          w_hrqNext   = 1'b0;
          if (priorityType) w_prioNext = w_rotated;
          if (terminalCount) w_softNext[r_grantCh] = 1'b0;
        end else if (!HLDA) begin
          w_stateNext = IDLE;
          w_gvNext    = 1'b0;
          w_hrqNext   = 1'b0;
        end
      end
      default: w_stateNext = IDLE;
    endcase

    // A software write lands after the TC clear so it wins a same-bit collision.
    if (reqWrite) w_softNext[reqData[1:0]] = reqData[2];

    if (masterClear) begin
      w_stateNext = IDLE;
      w_softNext  = '0;
      w_hrqNext   = 1'b0;
      w_gvNext    = 1'b0;
      w_gchNext   = 2'd0;
      w_prioNext  = PRIO_RESET;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state      <= IDLE;
      r_dreqQ      <= '0;
      r_softReq    <= '0;
      r_hrqReq     <= 1'b0;
      r_grantValid <= 1'b0;
      r_grantCh    <= 2'd0;
      r_prio       <= PRIO_RESET;
    end else begin
      r_state      <= w_stateNext;
      r_dreqQ      <= DREQ;
      r_softReq    <= w_softNext;
      r_hrqReq     <= w_hrqNext;
      r_grantValid <= w_gvNext;
      r_grantCh    <= w_gchNext;
      r_prio       <= w_prioNext;
    end
  end

  assign hrqReq        = r_hrqReq;
  assign grantValid    = r_grantValid;
  assign grantCh       = r_grantCh;
  assign priorityOrder = r_prio;
  assign DACK = ((r_state == ACTIVE) ? (NUM_CH'(1) << r_grantCh) : '0) ^ {NUM_CH{dackSense}};

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Self-checking bench for dma_priority_arbiter: a per-cycle vector table for the
// fixed/rotating/polarity flows plus directed sequences for the corner cases.
module tb_dma_priority_arbiter;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic [3:0] DREQ;
  logic       dreqSense, dackSense, priorityType;
  logic [3:0] maskReg;
  logic       reqWrite;
  logic [2:0] reqData;
  logic       masterClear, HLDA, serviceDone, terminalCount;
  logic       hrqReq, grantValid;
  logic [1:0] grantCh;
  logic [3:0] DACK;
  logic [7:0] priorityOrder;

  int nCompared = 0;
  int nMismatched = 0;

  typedef struct packed {
    logic [3:0] dreq;
    logic       ds;
    logic       ks;
    logic       pt;
    logic [3:0] mask;
    logic       hlda;
    logic       sDone;
    logic       expHrq;
    logic       expGv;
    logic [1:0] expGch;
    logic [3:0] expDack;
    logic [7:0] expPrio;
  } vec_t;

  vec_t vecs[30];

  dma_priority_arbiter #(.NUM_CH(4), .PRIO_RESET(8'b11_10_01_00)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .DREQ(DREQ), .dreqSense(dreqSense),
    .dackSense(dackSense), .priorityType(priorityType), .maskReg(maskReg),
    .reqWrite(reqWrite), .reqData(reqData), .masterClear(masterClear),
    .HLDA(HLDA), .serviceDone(serviceDone), .terminalCount(terminalCount),
    .hrqReq(hrqReq), .grantValid(grantValid), .grantCh(grantCh),
    .DACK(DACK), .priorityOrder(priorityOrder)
  );

  always #5 CLK = ~CLK;

  function automatic vec_t mk(input logic [3:0] dreq, input logic ds, input logic ks,
                              input logic pt, input logic [3:0] mask, input logic hlda,
                              input logic sDone, input logic hrq, input logic gv,
                              input logic [1:0] gch, input logic [3:0] dack,
                              input logic [7:0] prio);
    vec_t v;
    v = {dreq, ds, ks, pt, mask, hlda, sDone, hrq, gv, gch, dack, prio};
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    DREQ         = v.dreq;
    dreqSense    = v.ds;
    dackSense    = v.ks;
    priorityType = v.pt;
    maskReg      = v.mask;
    HLDA         = v.hlda;
    serviceDone  = v.sDone;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // Fixed priority, DREQ=1110, HLDA high.
    vecs[0]  = mk(4'hE, 0, 0, 0, 4'h0, 1, 0, 0, 0, 2'd0, 4'h0, 8'hE4);
    vecs[1]  = mk(4'hE, 0, 0, 0, 4'h0, 1, 0, 1, 1, 2'd1, 4'h0, 8'hE4);
    vecs[2]  = mk(4'hE, 0, 0, 0, 4'h0, 1, 0, 1, 1, 2'd1, 4'h2, 8'hE4);
    vecs[3]  = mk(4'h0, 0, 0, 0, 4'h0, 1, 1, 0, 0, 2'd1, 4'h0, 8'hE4);
    vecs[4]  = mk(4'h0, 0, 0, 0, 4'h0, 1, 0, 0, 0, 2'd1, 4'h0, 8'hE4);
    // Rotating priority, all four channels requesting.
    vecs[5]  = mk(4'hF, 0, 0, 1, 4'h0, 1, 0, 0, 0, 2'd1, 4'h0, 8'hE4);
    vecs[6]  = mk(4'hF, 0, 0, 1, 4'h0, 1, 0, 1, 1, 2'd0, 4'h0, 8'hE4);
    vecs[7]  = mk(4'hF, 0, 0, 1, 4'h0, 1, 0, 1, 1, 2'd0, 4'h1, 8'hE4);
    vecs[8]  = mk(4'hF, 0, 0, 1, 4'h0, 1, 1, 0, 0, 2'd0, 4'h0, 8'h39);
    vecs[9]  = mk(4'hF, 0, 0, 1, 4'h0, 1, 0, 1, 1, 2'd1, 4'h0, 8'h39);
    vecs[10] = mk(4'hF, 0, 0, 1, 4'h0, 1, 0, 1, 1, 2'd1, 4'h2, 8'h39);
    vecs[11] = mk(4'hF, 0, 0, 1, 4'h0, 1, 1, 0, 0, 2'd1, 4'h0, 8'h4E);
    vecs[12] = mk(4'hF, 0, 0, 1, 4'h0, 1, 0, 1, 1, 2'd2, 4'h0, 8'h4E);
    vecs[13] = mk(4'hF, 0, 0, 1, 4'h0, 1, 0, 1, 1, 2'd2, 4'h4, 8'h4E);
    vecs[14] = mk(4'hF, 0, 0, 1, 4'h0, 1, 1, 0, 0, 2'd2, 4'h0, 8'h93);
    vecs[15] = mk(4'hF, 0, 0, 1, 4'h0, 1, 0, 1, 1, 2'd3, 4'h0, 8'h93);
    vecs[16] = mk(4'hF, 0, 0, 1, 4'h0, 1, 0, 1, 1, 2'd3, 4'h8, 8'h93);
    vecs[17] = mk(4'hF, 0, 0, 1, 4'h0, 1, 1, 0, 0, 2'd3, 4'h0, 8'hE4);
    vecs[18] = mk(4'hF, 0, 0, 1, 4'h0, 1, 0, 1, 1, 2'd0, 4'h0, 8'hE4);
    vecs[19] = mk(4'hF, 0, 0, 1, 4'h0, 1, 0, 1, 1, 2'd0, 4'h1, 8'hE4);
    vecs[20] = mk(4'h0, 0, 0, 1, 4'h0, 1, 1, 0, 0, 2'd0, 4'h0, 8'h39);
    vecs[21] = mk(4'h0, 0, 0, 0, 4'h0, 1, 0, 0, 0, 2'd0, 4'h0, 8'hE4);
    // Inverted DREQ/DACK polarity, channel 0 requesting.
    vecs[22] = mk(4'hF, 1, 1, 0, 4'hF, 0, 0, 0, 0, 2'd0, 4'hF, 8'hE4);
    vecs[23] = mk(4'hE, 1, 1, 0, 4'h0, 0, 0, 0, 0, 2'd0, 4'hF, 8'hE4);
    vecs[24] = mk(4'hE, 1, 1, 0, 4'h0, 1, 0, 1, 1, 2'd0, 4'hF, 8'hE4);
    vecs[25] = mk(4'hE, 1, 1, 0, 4'h0, 1, 0, 1, 1, 2'd0, 4'hE, 8'hE4);
    vecs[26] = mk(4'hF, 1, 1, 0, 4'h0, 1, 1, 0, 0, 2'd0, 4'hF, 8'hE4);
    vecs[27] = mk(4'hF, 1, 1, 0, 4'h0, 1, 0, 0, 0, 2'd0, 4'hF, 8'hE4);
    vecs[28] = mk(4'h0, 0, 0, 0, 4'hF, 0, 0, 0, 0, 2'd0, 4'h0, 8'hE4);
    vecs[29] = mk(4'h0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 2'd0, 4'h0, 8'hE4);

    RESET_N = 1'b0;
    DREQ = 4'h0; dreqSense = 0; dackSense = 0; priorityType = 0; maskReg = 4'h0;
    reqWrite = 0; reqData = 3'b000; masterClear = 0; HLDA = 0;
    serviceDone = 0; terminalCount = 0;

    #12;
    checkOutput("resetHrq", {7'd0, hrqReq}, 8'h00);
    checkOutput("resetGv", {7'd0, grantValid}, 8'h00);
    checkOutput("resetGch", {6'd0, grantCh}, 8'h00);
    checkOutput("resetDack", {4'd0, DACK}, 8'h00);
    checkOutput("resetPrio", priorityOrder, 8'hE4);
    @(posedge CLK);
    #2 RESET_N = 1'b1;

    for (int i = 0; i < 30; i++) begin
      applyStimulus(vecs[i]);
      step();
      checkOutput($sformatf("vec%0d.hrq", i), {7'd0, hrqReq}, {7'd0, vecs[i].expHrq});
      checkOutput($sformatf("vec%0d.gv", i), {7'd0, grantValid}, {7'd0, vecs[i].expGv});
      checkOutput($sformatf("vec%0d.gch", i), {6'd0, grantCh}, {6'd0, vecs[i].expGch});
      checkOutput($sformatf("vec%0d.dack", i), {4'd0, DACK}, {4'd0, vecs[i].expDack});
      checkOutput($sformatf("vec%0d.prio", i), priorityOrder, vecs[i].expPrio);
    end

    // Fully masked hardware requests never raise hrqReq; a software request does.
    maskReg = 4'hF; DREQ = 4'hF; HLDA = 0; serviceDone = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      checkOutput($sformatf("maskHold%0d", i), {7'd0, hrqReq}, 8'h00);
    end
    reqWrite = 1; reqData = 3'b110;
    step();
    reqWrite = 0; reqData = 3'b000;
    checkOutput("softWriteEdge", {7'd0, hrqReq}, 8'h00);
    step();
    checkOutput("softHrq", {7'd0, hrqReq}, 8'h01);
    checkOutput("softGch", {6'd0, grantCh}, 8'h02);
    HLDA = 1;
    step();
    checkOutput("softDack", {4'd0, DACK}, 8'h04);
    serviceDone = 1; terminalCount = 1;
    step();
    serviceDone = 0; terminalCount = 0;
    checkOutput("softDone.dack", {4'd0, DACK}, 8'h00);
    checkOutput("softDone.hrq", {7'd0, hrqReq}, 8'h00);
    step();
    checkOutput("softCleared0", {7'd0, hrqReq}, 8'h00);
    step();
    checkOutput("softCleared1", {7'd0, hrqReq}, 8'h00);
    HLDA = 0; DREQ = 4'h0;
    step();
    maskReg = 4'h0;
    step();

    // One-cycle DREQ0 pulse with HLDA low: hrqReq for exactly one cycle.
    DREQ = 4'h1;
    step();
    DREQ = 4'h0;
    step();
    checkOutput("pulseHrqHigh", {7'd0, hrqReq}, 8'h01);
    step();
    checkOutput("pulseHrqLow", {7'd0, hrqReq}, 8'h00);
    checkOutput("pulseDack", {4'd0, DACK}, 8'h00);
    step();
    checkOutput("pulseIdle", {7'd0, grantValid}, 8'h00);

    // HLDA lost in ACTIVE under rotating mode: release without rotation.
    priorityType = 1; DREQ = 4'h4; HLDA = 1;
    step();
    step();
    step();
    checkOutput("hldaLoss.active", {4'd0, DACK}, 8'h04);
    HLDA = 0; DREQ = 4'h0;
    step();
    checkOutput("hldaLoss.hrq", {7'd0, hrqReq}, 8'h00);
    checkOutput("hldaLoss.dack", {4'd0, DACK}, 8'h00);
    checkOutput("hldaLoss.prio", priorityOrder, 8'hE4);
    step();

    // Asynchronous reset in ACTIVE after one rotation.
    DREQ = 4'h1; HLDA = 1;
    step();
    step();
    step();
    checkOutput("rstSetup.dack", {4'd0, DACK}, 8'h01);
    serviceDone = 1;
    step();
    serviceDone = 0;
    checkOutput("rstSetup.prio", priorityOrder, 8'h39);
    step();
    step();
    checkOutput("rstSetup.dack2", {4'd0, DACK}, 8'h01);
    #2 RESET_N = 1'b0;
    #1;
    checkOutput("asyncRst.dack", {4'd0, DACK}, 8'h00);
    checkOutput("asyncRst.hrq", {7'd0, hrqReq}, 8'h00);
    checkOutput("asyncRst.prio", priorityOrder, 8'hE4);
    DREQ = 4'h0;
    @(posedge CLK);
    #2 RESET_N = 1'b1;
    step();

    // masterClear coinciding with serviceDone suppresses the rotation.
    DREQ = 4'h2; HLDA = 1; priorityType = 1;
    step();
    step();
    checkOutput("mclrSetup.gch", {6'd0, grantCh}, 8'h01);
    step();
    checkOutput("mclrSetup.dack", {4'd0, DACK}, 8'h02);
    serviceDone = 1; masterClear = 1; DREQ = 4'h0;
    step();
    serviceDone = 0; masterClear = 0;
    checkOutput("mclr.prio", priorityOrder, 8'hE4);
    checkOutput("mclr.hrq", {7'd0, hrqReq}, 8'h00);
    checkOutput("mclr.gv", {7'd0, grantValid}, 8'h00);
    checkOutput("mclr.gch", {6'd0, grantCh}, 8'h00);
    checkOutput("mclr.dack", {4'd0, DACK}, 8'h00);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/dma_priority_arbiter.md
# dma_priority_arbiter

Channel request arbiter for the 4-channel DMA controller. It sits directly upstream of the timing-control state machine. It samples external DREQ lines and the software request register, applies masking and fixed or rotating priority, and latches one winning channel. It then raises a hold request toward the timing control and drives DACK for the winner until the timing control reports end of service. It owns the `priorityOrder` vector that downstream checkers observe.

## Interface
- `NUM_CH`, 4: channel count; only 4 is supported.
- `PRIO_RESET`, 8'b11_10_01_00: reset and fixed-mode priority order, as 2-bit fields. Field [1:0] is the highest priority, [7:6] the lowest.

Ports:
- `CLK`  in  1  system clock; all state changes on the rising edge.
- `RESET_N`  in  1  asynchronous, active-low reset.
- `DREQ`  in  4  external channel requests; polarity set by `dreqSense`.
- `dreqSense`  in  1  0: DREQ active-high; 1: active-low (command register bit).
- `dackSense`  in  1  0: DACK active-high; 1: active-low (command register bit).
- `priorityType`  in  1  0: fixed priority; 1: rotating priority (command register bit).
- `maskReg`  in  4  1 masks the corresponding channel's hardware DREQ.
- `reqWrite`  in  1  one-cycle strobe; writes the software request register.
- `reqData`  in  3  [2]: set (1) or clear (0); [1:0]: channel index.
- `masterClear`  in  1  synchronous clear of all arbiter state.
- `HLDA`  in  1  hold acknowledge from the CPU.
- `serviceDone`  in  1  one-cycle pulse from timing control at the end of the granted transfer (S4 → SI).
- `terminalCount`  in  1  qualifies `serviceDone`: the granted channel reached TC.
- `hrqReq`  out  1  registered; request to timing control / HRQ.
- `grantValid`  out  1  registered; a winner is latched.
- `grantCh`  out  2  registered; latched winner index.
- `DACK`  out  4  acknowledge, one-hot for the winner while in ACTIVE; polarity per `dackSense`.
- `priorityOrder`  out  8  current priority order.

## Operation
- **Input sampling:** `DREQ` is registered once into `dreqQ`. The arbiter never uses raw DREQ.
- **Request vector:** `effReq = ((dreqQ ^ {4{dreqSense}}) & ~maskReg) | softReq`. Software requests ignore `maskReg`.
- **Software request register:** `softReq[reqData[1:0]] <= reqData[2]` on `reqWrite`.
  - The bit for `grantCh` clears when `serviceDone && terminalCount` in ACTIVE.
  - If a `reqWrite` hits the same bit in that same cycle, the write wins.
- **Winner selection:** the first channel with `effReq` set, scanning `priorityOrder` fields from [1:0] to [7:6].
- **State machine:** IDLE, REQ, ACTIVE.
  - IDLE: if `effReq != 0`, latch the winner into `grantCh`, set `grantValid` and `hrqReq`, and go to REQ.
  - REQ: the winner is frozen; a higher-priority request arriving now does not preempt it.
    - If the winner's `effReq` bit drops while `HLDA == 0`, clear `grantValid`/`hrqReq` and go to IDLE.
    - Else if `HLDA == 1`, go to ACTIVE.
  - ACTIVE: `DACK` is asserted for `grantCh`; `hrqReq` stays high.
    - On `serviceDone`, go to IDLE and clear `grantValid`/`hrqReq`.
    - If `HLDA` falls before `serviceDone`, go to IDLE with no priority update.
- **DACK:** `DACK = (ACTIVE ? onehot(grantCh) : 4'b0000) ^ {4{dackSense}}`. It is combinational from registered state and `dackSense` only.
- **Priority order:**
  - When `priorityType == 0`, `priorityOrder` reloads `PRIO_RESET` every cycle.
  - When `priorityType == 1` and `serviceDone` occurs in ACTIVE for channel k, the order becomes {k, k+3, k+2, k+1} mod 4, listed from [7:6] down to [1:0]. Channel k becomes lowest and k+1 highest.
- **`masterClear`:**
  - State goes to IDLE and `softReq` to 0.
  - `priorityOrder` goes to `PRIO_RESET`, and `grantValid`, `hrqReq` and `grantCh` go to 0.
  - It overrides every other event in that cycle.
- **Reset values** (`RESET_N` low, asynchronous):
  - State IDLE, `dreqQ` = 0, `softReq` = 0.
  - `hrqReq` = 0, `grantValid` = 0, `grantCh` = 0.
  - `priorityOrder` = `PRIO_RESET`.
  - `DACK` = {4{dackSense}} (inactive).

## Timing
- **DREQ to hrqReq:** 2 cycles. DREQ is sampled at edge n into `dreqQ`; the winner and `hrqReq` are registered at edge n+1.
- **Software request to hrqReq:** a `reqWrite` at edge n sets `softReq`; `hrqReq` rises at edge n+1.
- **HLDA to DACK:** 1 cycle. HLDA is seen high at edge m, the state becomes ACTIVE and DACK is valid after edge m.
- **serviceDone to release:** `serviceDone` at edge p clears DACK, `hrqReq` and `grantValid`, and applies the rotation after edge p.
- **Re-arbitration:** the earliest new grant comes at edge p+1, using the updated order. There is always at least one IDLE cycle between grants.
- **Fixed/rotating mode change:** `priorityType` changes take effect at the next winner selection. A latched grant is never altered.
- **Reset mid-transfer:** `RESET_N` asserted in ACTIVE drops DACK immediately (asynchronously) to the inactive level.

## Test plan
- **Fixed priority:** `priorityType`=0, senses 0, mask 0, DREQ=4'b1110, HLDA tied high → `hrqReq` at +2 cycles, DACK=4'b0010 at +3; `serviceDone` → DACK=4'b0000 next cycle, `priorityOrder` stays 8'b11_10_01_00.
- **Rotating priority:** `priorityType`=1, DREQ=4'b1111 held, `serviceDone` after each grant → DACK sequence 0001, 0010, 0100, 1000, 0001; `priorityOrder` after the first service = 8'b00_11_10_01.
- **Mask and software request:** `maskReg`=4'b1111, DREQ=4'b1111 → no `hrqReq` for 10 cycles. Then `reqWrite` with `reqData`=3'b110 → `hrqReq` next cycle, DACK=4'b0100 after HLDA; `serviceDone`+`terminalCount` clears `softReq[2]`.
- **Polarity:** `dreqSense`=1, `dackSense`=1, DREQ=4'b1110 (channel 0 active) → DACK=4'b1110 in ACTIVE, 4'b1111 otherwise.
- **Request withdrawal and HLDA loss:**
  - DREQ0 pulsed high 1 cycle with HLDA low → `hrqReq` high exactly 1 cycle, then IDLE, no DACK.
  - HLDA dropped in ACTIVE → IDLE, `priorityOrder` unchanged.
- **Reset and master clear:**
  - `RESET_N` low in ACTIVE → DACK inactive, `hrqReq`=0, `priorityOrder`=8'b11_10_01_00, with no clock edge required.
  - `masterClear` coinciding with `serviceDone` → `priorityOrder`=8'b11_10_01_00, with no rotation.
